seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
Moore-style serial pattern transmitter, the source side of the team's serial sequence detectors. On a start request it latches a PAT_W-bit pattern (default 1001) and shifts it out MSB-first, one bit per clock. The pattern is repeated a programmable number of times with an optional idle gap between copies. Used to drive the detector FSMs in loopback and as a standalone stimulus source.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
PAT_DEFAULT, 4'b1001, pattern loaded when pattern input is all-zero
CNT_W, 8, width of repeat_cnt
GAP_W, 4, width of gap

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  pattern to send; 0 selects PAT_DEFAULT
repeat_cnt  input  CNT_W  total copies sent = repeat_cnt+1
gap  input  GAP_W  idle cycles between copies
dout  output  1  serial data, MSB first
dvalid  output  1  high while dout carries a pattern bit
frame_start  output  1  high during the first bit of every copy
busy  output  1  high in SHIFT and GAP
done  output  1  one-cycle pulse after the last bit of the last copy

Behaviour:
- States: IDLE, SHIFT, GAP, DONE. All outputs decode from state and registers only (Moore). No input reaches an output combinationally.
- Reset (reset=0, asynchronous): state=IDLE, shift reg=0, counters=0. dout, dvalid, frame_start, busy and done are 0 immediately, without waiting for a clock edge. Reset mid-frame abandons the frame; no done pulse is generated.
- IDLE: when start=1 at edge k:
  - latch pattern (or PAT_DEFAULT if pattern==0), repeat_cnt and gap into internal registers;
  - load the shift reg and set bit_idx=0, rep=0;
  - go to SHIFT.
  - The first bit is visible in the cycle after edge k (latency 1).
- SHIFT:
  - dout = shreg[PAT_W-1]; dvalid=1; busy=1; frame_start=(bit_idx==0).
  - Each edge: shift left, bit_idx++.
  - On the edge ending the bit with bit_idx==PAT_W-1:
    - if rep==latched repeat_cnt -> DONE;
    - else if latched gap==0 -> reload shreg, bit_idx=0, rep++, stay in SHIFT (back-to-back copies, no bubble);
    - else -> GAP with gap_cnt=latched gap.
- GAP:
  - dout=0, dvalid=0, busy=1.
  - gap_cnt decrements each edge.
  - On the edge where gap_cnt==1: reload shreg, rep++, bit_idx=0, go to SHIFT.
  - Exactly gap idle cycles are inserted.
- DONE: done=1, busy=0, dout=0, dvalid=0 for one cycle, then IDLE. start is ignored in DONE.
- start while busy or in DONE is ignored. pattern, repeat_cnt and gap may change freely after latching without effect.
- Counter widths:
  - rep is CNT_W bits; repeat_cnt = 2^CNT_W-1 sends 2^CNT_W copies with no wrap error.
  - bit_idx is clog2(PAT_W) bits.
- Total frame length from first bit to done: (repeat_cnt+1)*PAT_W + repeat_cnt*gap cycles, then done on the following cycle.

Optional Feature:
SEQ_GEN_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 sampled in SHIFT or GAP forces IDLE at that edge. No done pulse; busy and dvalid drop in the next cycle. abort in IDLE or DONE has no effect. abort takes priority over every other transition.
- Undefined: the port and its logic are absent, and a started frame always runs to DONE.

Test Plan:
1. reset low 3 cycles then high, start=1 for 1 cycle, pattern=0, repeat_cnt=0, gap=0 -> dout 1,0,0,1 with dvalid=1 in cycles 1-4, frame_start only in cycle 1, done=1 in cycle 5, then IDLE.
2. pattern=4'b1011, repeat_cnt=2, gap=0 -> 12 contiguous dvalid bits 1011 1011 1011, frame_start in cycles 1, 5 and 9, done in cycle 13. Feeding dout to the team's non-overlapping 1001/1011 detector gives exactly 3 detections.
3. pattern=4'b1001, repeat_cnt=1, gap=3 -> bits in cycles 1-4, dvalid=0 and busy=1 in cycles 5-7, bits in cycles 8-11, done in cycle 12.
4. start re-asserted in cycle 2 with pattern=4'b1111 during a frame -> ignored, output stays 1001; a start in the done cycle is also ignored.
5. reset driven low asynchronously mid-bit in cycle 3 of a frame -> all outputs 0 before the next edge, no done pulse, and a new start after release behaves as in test 1.
6. (SEQ_GEN_ABORT_EN) abort=1 in cycle 2 of repeat_cnt=3 frame -> IDLE after that edge, dvalid=0 and busy=0 next cycle, done never asserted.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// Handshake/data bundle for seq_pattern_gen: request side (start, pattern, repeat_cnt, gap) and serial output side.
// Optional abort input under SEQ_GEN_ABORT_EN.
interface seq_pattern_gen_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
`ifdef SEQ_GEN_ABORT_EN
  logic             abort;
`endif
  logic             dout;
  logic             dvalid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
`ifdef SEQ_GEN_ABORT_EN
    output abort,
`endif
    output start, pattern, repeat_cnt, gap,
    input  dout, dvalid, frame_start, busy, done
  );

  modport slave (
`ifdef SEQ_GEN_ABORT_EN
    input  abort,
`endif
    input  start, pattern, repeat_cnt, gap,
    output dout, dvalid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Moore serial pattern transmitter: repeats a latched pattern MSB-first with optional idle gaps between copies.
// Build option SEQ_GEN_ABORT_EN adds an abort input that returns SHIFT/GAP to IDLE without a done pulse.
module seq_pattern_gen #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1001),
  parameter int unsigned      CNT_W       = 8,
  parameter int unsigned      GAP_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  seq_pattern_gen_if.slave    bus
);
  localparam int unsigned BIDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t              state_q, state_n;
  logic [PAT_W-1:0]    shreg_q, shreg_n;
  logic [PAT_W-1:0]    pat_q, pat_n;
  logic [BIDX_W-1:0]   bidx_q, bidx_n;
  logic [CNT_W-1:0]    rep_q, rep_n;
  logic [CNT_W-1:0]    rcnt_q, rcnt_n;
  logic [GAP_W-1:0]    gcnt_q, gcnt_n;
  logic [GAP_W-1:0]    gap_q, gap_n;
  logic                dout_q, dout_n;
  logic                dvalid_q, dvalid_n;
  logic                fstart_q, fstart_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                abort_c;

`ifdef SEQ_GEN_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // State and datapath registers; outputs are registered decodes of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      pat_q    <= '0;
      bidx_q   <= '0;
      rep_q    <= '0;
      rcnt_q   <= '0;
      gcnt_q   <= '0;
      gap_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      fstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      shreg_q  <= shreg_n;
      pat_q    <= pat_n;
      bidx_q   <= bidx_n;
      rep_q    <= rep_n;
      rcnt_q   <= rcnt_n;
      gcnt_q   <= gcnt_n;
      gap_q    <= gap_n;
      dout_q   <= dout_n;
      dvalid_q <= dvalid_n;
      fstart_q <= fstart_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state, datapath update and output decode
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    pat_n   = pat_q;
    bidx_n  = bidx_q;
    rep_n   = rep_q;
    rcnt_n  = rcnt_q;
    gcnt_n  = gcnt_q;
    gap_n   = gap_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_n   = (bus.pattern == '0) ? PAT_DEFAULT : bus.pattern;
          rcnt_n  = bus.repeat_cnt;
          gap_n   = bus.gap;
          shreg_n = pat_n;
          bidx_n  = '0;
          rep_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n = {shreg_q[PAT_W-2:0], 1'b0};
        bidx_n  = bidx_q + BIDX_W'(1);
        if (bidx_q == BIDX_W'(PAT_W - 1)) begin
          if (rep_q == rcnt_q) begin
            state_n = DONE;
          end else if (gap_q == '0) begin
            shreg_n = pat_q;
            bidx_n  = '0;
            rep_n   = rep_q + CNT_W'(1);
          end else begin
            gcnt_n  = gap_q;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        gcnt_n = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) begin
          shreg_n = pat_q;
          bidx_n  = '0;
          rep_n   = rep_q + CNT_W'(1);
          state_n = SHIFT;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Abort overrides every other transition out of an active frame
    if (abort_c && ((state_q == SHIFT) || (state_q == GAP))) begin
      state_n = IDLE;
    end

    dout_n   = (state_n == SHIFT) ? shreg_n[PAT_W-1] : 1'b0;
    dvalid_n = (state_n == SHIFT);
    fstart_n = (state_n == SHIFT) && (bidx_n == '0);
    busy_n   = (state_n == SHIFT) || (state_n == GAP);
    done_n   = (state_n == DONE);
  end

  assign bus.dout        = dout_q;
  assign bus.dvalid      = dvalid_q;
  assign bus.frame_start = fstart_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
